matmul_host_ctrl: RTL

MATMUL_HOST_CTRL -- requirements
Module: matmul_host_ctrl

---
 rtl/matmul_host_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/matmul_host_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_host_ctrl
//   Host-side sequencer for a matrix multiplier. It streams matrix A and then
//   matrix B in element by element (row-major), pulses start, waits for the
//   multiplier's done level, captures C and streams it back out element by
//   element with out_last on the final element.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data      input element stream (A beats then B beats)
//   matrix_a, matrix_b             packed operands to the multiplier
//   start                          one-cycle multiply request
//   done, result_c                 completion level and packed C from multiplier
//   out_valid/out_ready/out_data/out_last   result element stream
//   busy                           high while a multiply is started, running or draining
//   o_dbg_state                    current FSM state, for observation only
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high. A source holding valid keeps its data stable until the transfer;
// ready never depends combinationally on valid.
// -----------------------------------------------------------------------------
module matmul_host_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 8,
    parameter int N          = 8,
    parameter int P          = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic [M*N*DATA_WIDTH-1:0]    matrix_a,
    output logic [N*P*DATA_WIDTH-1:0]    matrix_b,
    output logic                         start,
    input  logic                         done,
    input  logic [M*P*DATA_WIDTH-1:0]    result_c,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic                         busy,
    output logic [2:0]                   o_dbg_state
);

    localparam int NUM_A   = M * N;
    localparam int NUM_B   = N * P;
    localparam int NUM_C   = M * P;
    localparam int MAX_AB  = (NUM_A > NUM_B) ? NUM_A : NUM_B;
    localparam int MAX_ALL = (MAX_AB > NUM_C) ? MAX_AB : NUM_C;
    localparam int IDX_W   = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = 1;
    localparam logic [IDX_W-1:0] LAST_A   = IDX_W'(NUM_A - 1);
    localparam logic [IDX_W-1:0] LAST_B   = IDX_W'(NUM_B - 1);
    localparam logic [IDX_W-1:0] LAST_C   = IDX_W'(NUM_C - 1);

    localparam logic [2:0] ST_LOAD_A = 3'd0;
    localparam logic [2:0] ST_LOAD_B = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    logic [2:0]                   r_state;
    logic [IDX_W-1:0]             r_idx;
    logic [M*N*DATA_WIDTH-1:0]    r_a;
    logic [N*P*DATA_WIDTH-1:0]    r_b;
    logic [M*P*DATA_WIDTH-1:0]    r_c;

    logic w_loading;
    logic w_in_fire;
    logic w_out_fire;
    int   w_c_idx;

    assign w_loading  = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
    assign w_in_fire  = in_valid && w_loading;
    assign w_out_fire = (r_state == ST_DRAIN) && out_ready;

    // The shared index can exceed the C range while loading a larger operand;
    // clamp the read select so out_data never reads past r_c.
    assign w_c_idx = (int'(r_idx) < NUM_C) ? int'(r_idx) : 0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD_A;
            r_idx   <= IDX_ZERO;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
        end else begin
            case (r_state)
                ST_LOAD_A: begin
                    if (w_in_fire) begin
                        r_a[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                        if (r_idx == LAST_A) begin
                            r_idx   <= IDX_ZERO;
                            r_state <= ST_LOAD_B;
                        end else begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (w_in_fire) begin
                        r_b[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                        if (r_idx == LAST_B) begin
                            r_idx   <= IDX_ZERO;
                            r_state <= ST_START;
                        end else begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done is a level; the first high sample ends the wait.
                    if (done) begin
                        r_c     <= result_c;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_out_fire) begin
                        if (r_idx == LAST_C) begin
                            r_idx   <= IDX_ZERO;
                            r_state <= ST_LOAD_A;
                        end else begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_LOAD_A;
                    r_idx   <= IDX_ZERO;
                end
            endcase
        end
    end

    assign in_ready    = w_loading;
    assign start       = (r_state == ST_START);
    assign out_valid   = (r_state == ST_DRAIN);
    assign out_data    = r_c[w_c_idx*DATA_WIDTH +: DATA_WIDTH];
    assign out_last    = (r_state == ST_DRAIN) && (r_idx == LAST_C);
    assign busy        = (r_state == ST_START) || (r_state == ST_WAIT) ||
                         (r_state == ST_DRAIN);
    assign matrix_a    = r_a;
    assign matrix_b    = r_b;
    assign o_dbg_state = r_state;

endmodule
